// File: rtl/mmcm_rst_seq.sv
// MMCM reset sequencer: pulses the MMCM reset, qualifies lock stability, then releases system reset (WATCHDOG_EN adds lock-timeout retry).
// Latency: rst_n_out rises LOCK_STABLE_CYC+2 edges after locked_in is first sampled high; falls on the 3rd edge after lock loss.
// Backpressure: none; soft_rst_req is a one-cycle request, ignored while the MMCM reset pulse is already running.
module mmcm_rst_seq #(
    parameter int MMCM_RST_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       locked_in,
    input  logic       soft_rst_req,
    output logic       mmcm_rst,
    output logic       rst_n_out,
    output logic       clk_ready,
    output logic [7:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam int MAX_AB  = (MMCM_RST_CYC > LOCK_STABLE_CYC) ? MMCM_RST_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(MMCM_RST_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYC - 1);
`ifdef WATCHDOG_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_MMCM_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sync_ff1;
    logic          sync_lk;
`ifdef WATCHDOG_EN
    logic          retry_inc;
    logic [7:0]    retry_q;
`endif

    // locked_in comes from the MMCM's own domain; only sync_lk is used below.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_ff1 <= 1'b0;
            sync_lk  <= 1'b0;
        end else begin
            sync_ff1 <= locked_in;
            sync_lk  <= sync_ff1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef WATCHDOG_EN
        retry_inc = 1'b0;
`endif
        if (soft_rst_req && (state_q == ST_WAIT_LOCK || state_q == ST_STABLE || state_q == ST_RUN)) begin
            state_d = ST_MMCM_RST;
        end else begin
            case (state_q)
                ST_MMCM_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (sync_lk) begin
                        state_d = ST_STABLE;
`ifdef WATCHDOG_EN
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d   = ST_MMCM_RST;
                        retry_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
`endif
                    end
                end
                ST_STABLE: begin
                    if (!sync_lk) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!sync_lk) begin
                        state_d = ST_MMCM_RST;
                    end
                end
                default: begin
                    state_d = ST_MMCM_RST;
                end
            endcase
        end
        // Every phase measures its own duration from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Outputs decode the next state so they move on the same edge as the transition.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_MMCM_RST;
            cnt_q     <= '0;
            mmcm_rst  <= 1'b1;
            rst_n_out <= 1'b0;
            clk_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mmcm_rst  <= (state_d == ST_MMCM_RST);
            rst_n_out <= (state_d == ST_RUN);
            clk_ready <= (state_d == ST_RUN);
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            retry_q <= 8'd0;
        end else if (retry_inc && (retry_q != 8'hFF)) begin
            retry_q <= retry_q + 8'd1;
        end
    end

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 8'd0;
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// Bench for mmcm_rst_seq: phase-timeline model compared every cycle, plus literal latency checks.
module tb_mmcm_rst_seq;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       locked_in;
    logic       soft_rst_req;
    logic       mmcm_rst;
    logic       rst_n_out;
    logic       clk_ready;
    logic [7:0] retry_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    mmcm_rst_seq #(
        .MMCM_RST_CYC     (P_RST),
        .LOCK_STABLE_CYC  (P_STB),
        .LOCK_TIMEOUT_CYC (P_TO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .locked_in    (locked_in),
        .soft_rst_req (soft_rst_req),
        .mmcm_rst     (mmcm_rst),
        .rst_n_out    (rst_n_out),
        .clk_ready    (clk_ready),
        .retry_cnt    (retry_cnt),
        .state_o      (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 reset pulse, 1 wait lock, 2 stability window, 3 run.
    // Each phase is timed by edges elapsed since the edge that entered it.
    int   m_phase, m_enter, m_edge, m_retry, m_el, m_nxt;
    logic m_h0, m_h1, m_lk;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_phase = 0; m_enter = 0; m_edge = 0; m_retry = 0;
            m_h0 = 1'b0; m_h1 = 1'b0;
        end else begin
            m_edge++;
            m_lk = m_h1; m_h1 = m_h0; m_h0 = locked_in;
            m_el  = m_edge - m_enter;
            m_nxt = m_phase;
            if (soft_rst_req && m_phase != 0) begin
                m_nxt = 0;
            end else if (m_phase == 0) begin
                if (m_el == P_RST) m_nxt = 1;
            end else if (m_phase == 1) begin
                if (m_lk) m_nxt = 2;
`ifdef WATCHDOG_EN
                else if (m_el == P_TO) begin
                    m_nxt = 0;
                    if (m_retry < 255) m_retry++;
                end
`endif
            end else if (m_phase == 2) begin
                if (!m_lk) m_nxt = 1;
                else if (m_el == P_STB) m_nxt = 3;
            end else begin
                if (!m_lk) m_nxt = 0;
            end
            if (m_nxt != m_phase) m_enter = m_edge;
            m_phase = m_nxt;
        end
    end

    always @(negedge sys_clk) begin
        check("mdl_state_o", state_o, m_phase);
        check("mdl_mmcm_rst", mmcm_rst, (m_phase == 0));
        check("mdl_rst_n_out", rst_n_out, (m_phase == 3));
        check("mdl_clk_ready", clk_ready, (m_phase == 3));
        check("mdl_retry_cnt", retry_cnt, m_retry);
    end

    task automatic tick(input int k);
        repeat (k) @(posedge sys_clk);
        #1;
    endtask

    // Edges until the chosen output (0: mmcm_rst, 1: rst_n_out) equals val; -1 on timeout.
    task automatic count_edges(input int which, input logic val, input int budget, output int n);
        logic s;
        n = 0;
        forever begin
            @(posedge sys_clk); #1; n++;
            s = (which == 0) ? mmcm_rst : rst_n_out;
            if (s == val) break;
            if (n >= budget) begin n = -1; break; end
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output int n);
        n = 0;
        forever begin
            @(posedge sys_clk); #1; n++;
            if (state_o == st) break;
            if (n >= budget) begin n = -1; break; end
        end
    endtask

    initial begin
        int n;
        sys_rst_n = 1'b1; locked_in = 1'b0; soft_rst_req = 1'b0;
        #1 sys_rst_n = 1'b0;
        #2;
        check("rst_mmcm_rst", mmcm_rst, 1);
        check("rst_rst_n_out", rst_n_out, 0);
        check("rst_clk_ready", clk_ready, 0);
        check("rst_state_o", state_o, 0);
        check("rst_retry_cnt", retry_cnt, 0);

        // Power-up sequence.
        @(negedge sys_clk); sys_rst_n = 1'b1;
        count_edges(0, 1'b0, 50, n);
        check("t1_pulse_len", n, 4);
        tick(2); locked_in = 1'b1;
        tick(1);
        count_edges(1, 1'b1, 100, n);
        check("t1_lock_to_run", n, 10);
        check("t1_clk_ready", clk_ready, 1);

        // Lock loss in RUN, then relock.
        locked_in = 1'b0;
        count_edges(1, 1'b0, 20, n);
        check("t3_loss_edges", n, 3);
        check("t3_mmcm_rst", mmcm_rst, 1);
        check("t3_clk_ready", clk_ready, 0);
        count_edges(0, 1'b0, 20, n);
        check("t3_pulse_len", n, 4);
        tick(2); locked_in = 1'b1;
        tick(1);
        count_edges(1, 1'b1, 100, n);
        check("t3_relock", n, 10);

        // Soft reset in RUN; a second request inside the pulse is ignored.
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("t4_state_o", state_o, 0);
        check("t4_mmcm_rst", mmcm_rst, 1);
        n = 0;
        forever begin
            @(posedge sys_clk); #1; n++;
            soft_rst_req = (n == 1);
            if (!mmcm_rst || n > 20) break;
        end
        soft_rst_req = 1'b0;
        check("t4_pulse_len", n, 4);

        // Lock glitch inside the stability window restarts the count.
        wait_state(3'd2, 20, n);
        check("t2_enter_stable", (n > 0), 1);
        tick(2); locked_in = 1'b0;
        tick(1); locked_in = 1'b1;
        wait_state(3'd1, 20, n);
        check("t2_back_to_wait", n, 2);
        check("t2_rst_n_low", rst_n_out, 0);
        wait_state(3'd2, 20, n);
        check("t2_restable", n, 1);
        count_edges(1, 1'b1, 50, n);
        check("t2_full_recount", n, 8);

        // Lock held low: watchdog retries or indefinite wait.
        locked_in = 1'b0;
        count_edges(0, 1'b1, 20, n);
        check("t5_loss_edges", n, 3);
        count_edges(0, 1'b0, 20, n);
        check("t5_pulse_len", n, 4);
`ifdef WATCHDOG_EN
        for (int r = 1; r <= 3; r++) begin
            count_edges(0, 1'b1, 100, n);
            check("t5_timeout_gap", n, 32);
            check("t5_retry_cnt", retry_cnt, r);
            count_edges(0, 1'b0, 20, n);
            check("t5_repulse_len", n, 4);
        end
        // Lock arriving on the timeout edge wins.
        tick(29); locked_in = 1'b1;
        tick(3);
        check("t5_lock_wins_state", state_o, 2);
        check("t5_lock_wins_retry", retry_cnt, 3);
        locked_in = 1'b0;
        tick(253 * 36 + 20);
        check("t5_retry_sat", retry_cnt, 255);
`else
        tick(200);
        check("t5_wait_state", state_o, 1);
        check("t5_retry_zero", retry_cnt, 0);
        check("t5_mmcm_low", mmcm_rst, 0);
`endif
        locked_in = 1'b1;
        wait_state(3'd3, 200, n);
        check("t5_relock_run", (n > 0), 1);

        // Asynchronous reset mid-RUN.
        #3 sys_rst_n = 1'b0;
        #1;
        check("t6_mmcm_rst", mmcm_rst, 1);
        check("t6_rst_n_out", rst_n_out, 0);
        check("t6_clk_ready", clk_ready, 0);
        check("t6_state_o", state_o, 0);
        check("t6_retry_cnt", retry_cnt, 0);
        @(negedge sys_clk); #2 sys_rst_n = 1'b1;
        count_edges(0, 1'b0, 20, n);
        check("t6_pulse_len", n, 4);
        count_edges(1, 1'b1, 50, n);
        check("t6_restart_run", n, 9);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
